control_pipe: RTL and testbench

- Registered successor to the combinational pipeline control decoder.
- Decodes the IF/ID instruction fields into the control bundle and registers it into the ID/EX stage.
- Adds load-use hazard detection with a configurable stall length, flush handling, a sticky illegal-instruction flag, and an optional multi-cycle mult/div busy interlock.
- Sits between the IF/ID register and the ID/EX register; oStall drives the PC and IF/ID hold enables.

---
 rtl/control_pipe.sv | 175 +++++++++++++++++
 tb/tb_control_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Registered ID-stage control: decodes IF/ID fields into the ID/EX control bundle,
// with load-use stall, flush and sticky illegal flag. CTRL_MULDIV_EN adds a mult/div busy interlock.
module control_pipe #(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int MULDIV_LAT     = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iValid,
  input  logic [5:0]            iOp,
  input  logic [5:0]            iFunct,
  input  logic [REG_ADDR_W-1:0] iRs,
  input  logic [REG_ADDR_W-1:0] iRt,
  input  logic [REG_ADDR_W-1:0] iRd,
  input  logic                  iFlush,
  output logic                  oValid,
  output logic [1:0]            oRegDst,
  output logic [1:0]            oOrigALU,
  output logic [1:0]            oMemparaReg,
  output logic                  oEscreveReg,
  output logic                  oLeMem,
  output logic                  oEscreveMem,
  output logic                  oJump,
  output logic                  oBranch,
  output logic                  onBranch,
  output logic                  oJr,
  output logic [1:0]            oOpALU,
  output logic [2:0]            oOrigPC,
  output logic [REG_ADDR_W-1:0] oDestReg,
  output logic                  oStall,
  output logic                  oIllegal
);

  typedef struct packed {
    logic                  valid;
    logic [1:0]            regdst;
    logic [1:0]            origalu;
    logic [1:0]            memreg;
    logic                  wr;
    logic                  rdm;
    logic                  wrm;
    logic                  jump;
    logic                  br;
    logic                  nbr;
    logic                  jr;
    logic [1:0]            opalu;
    logic [2:0]            origpc;
    logic [REG_ADDR_W-1:0] dest;
  } ctrl_t;

  localparam logic [2:0] STALL_LD = 3'(LOAD_STALL_CYC - 1);

  ctrl_t      dec, q, nxt;
  logic       dec_ill, dec_rdrt;
  logic [2:0] stall_cnt, stall_nxt;
  logic       ill_q;
  logic       hz, md_stall, capture;

  always_comb begin
    dec      = '0;
    dec_ill  = 1'b0;
    dec_rdrt = 1'b0;
    unique case (iOp)
      6'h23: begin dec.origalu = 2'b01; dec.wr = 1'b1; dec.rdm = 1'b1; end
      6'h2B: begin dec.origalu = 2'b01; dec.wrm = 1'b1; dec_rdrt = 1'b1; end
      6'h04: begin dec.origpc = 3'b001; dec.br = 1'b1; dec.opalu = 2'b01; dec_rdrt = 1'b1; end
      6'h05: begin dec.origpc = 3'b101; dec.nbr = 1'b1; dec.opalu = 2'b01; dec_rdrt = 1'b1; end
      6'h00: begin
        dec_rdrt  = 1'b1;
        dec.opalu = 2'b10;
        unique case (iFunct)
          6'h08: begin dec.origpc = 3'b010; dec.jump = 1'b1; dec.jr = 1'b1; end
          6'h0C: begin
            dec.regdst = 2'b10; dec.memreg = 2'b10; dec.wr = 1'b1;
            dec.origpc = 3'b100; dec.jump = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          6'h18, 6'h19, 6'h1A, 6'h1B: ;
`endif
          default: begin dec.regdst = 2'b01; dec.memreg = 2'b01; dec.wr = 1'b1; end
        endcase
      end
      6'h02: begin dec.origpc = 3'b010; dec.jump = 1'b1; end
      6'h03: begin
        dec.regdst = 2'b10; dec.memreg = 2'b10; dec.wr = 1'b1;
        dec.origpc = 3'b010; dec.jump = 1'b1;
      end
      6'h08, 6'h09, 6'h0C, 6'h0E: begin
        dec.origalu = 2'b01; dec.memreg = 2'b01; dec.wr = 1'b1; dec.opalu = 2'b11;
      end
      6'h0D: begin dec.origalu = 2'b10; dec.memreg = 2'b01; dec.wr = 1'b1; dec.opalu = 2'b11; end
      6'h0F: begin dec.origalu = 2'b11; dec.memreg = 2'b11; dec.wr = 1'b1; end
      default: begin dec.origpc = 3'b111; dec_ill = 1'b1; end
    endcase
    unique case (dec.regdst)
      2'b00:   dec.dest = iRt;
      2'b01:   dec.dest = iRd;
      2'b10:   dec.dest = REG_ADDR_W'(31);
      default: dec.dest = '0;
    endcase
    dec.valid = iValid;
  end

  // Only the instruction sitting in EX can be a hazard source; after the first bubble oValid is 0.
  assign hz = q.valid & q.rdm & (q.dest != '0) & iValid &
              ((q.dest == iRs) | ((q.dest == iRt) & dec_rdrt));

`ifdef CTRL_MULDIV_EN
  localparam logic [3:0] BUSY_LD = 4'(MULDIV_LAT - 1);
  logic [3:0] busy_cnt, busy_nxt;
  logic       dec_md, dec_mfhl;

  assign dec_md   = (iOp == 6'h00) & (iFunct[5:2] == 4'b0110);
  assign dec_mfhl = (iOp == 6'h00) & ((iFunct == 6'h10) | (iFunct == 6'h12));
  assign md_stall = iValid & (busy_cnt != 4'd0) & (dec_md | dec_mfhl);

  always_comb begin
    busy_nxt = '0;
    if (iFlush)                 busy_nxt = '0;
    else if (capture & dec_md)  busy_nxt = BUSY_LD;
    else if (busy_cnt != 4'd0)  busy_nxt = busy_cnt - 4'd1;
  end

  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) busy_cnt <= '0;
    else         busy_cnt <= busy_nxt;
`else
  assign md_stall = 1'b0;
`endif

  always_comb begin
    nxt       = '0;
    capture   = 1'b0;
    stall_nxt = stall_cnt;
    if (iFlush)                  stall_nxt = '0;
    else if (md_stall)           stall_nxt = (stall_cnt != 3'd0) ? stall_cnt - 3'd1 : 3'd0;
    else if (stall_cnt != 3'd0)  stall_nxt = stall_cnt - 3'd1;
    else if (hz)                 stall_nxt = STALL_LD;
    else if (iValid) begin
      nxt     = dec;
      capture = 1'b1;
    end
  end

  assign oStall = ~iFlush & (md_stall | hz | (stall_cnt != 3'd0));

  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      q         <= '0;
      stall_cnt <= '0;
      ill_q     <= 1'b0;
    end else begin
      q         <= nxt;
      stall_cnt <= stall_nxt;
      ill_q     <= ill_q | (capture & dec_ill);
    end

  assign oValid      = q.valid;
  assign oRegDst     = q.regdst;
  assign oOrigALU    = q.origalu;
  assign oMemparaReg = q.memreg;
  assign oEscreveReg = q.wr;
  assign oLeMem      = q.rdm;
  assign oEscreveMem = q.wrm;
  assign oJump       = q.jump;
  assign oBranch     = q.br;
  assign onBranch    = q.nbr;
  assign oJr         = q.jr;
  assign oOpALU      = q.opalu;
  assign oOrigPC     = q.origpc;
  assign oDestReg    = q.dest;
  assign oIllegal    = ill_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe (LOAD_STALL_CYC=2, MULDIV_LAT=4).
module tb_control_pipe;
  logic       iCLK = 1'b0;
  logic       iRST_n, iValid, iFlush;
  logic [5:0] iOp, iFunct;
  logic [4:0] iRs, iRt, iRd;
  logic       oValid, oEscreveReg, oLeMem, oEscreveMem, oJump, oBranch, onBranch, oJr;
  logic [1:0] oRegDst, oOrigALU, oMemparaReg, oOpALU;
  logic [2:0] oOrigPC;
  logic [4:0] oDestReg;
  logic       oStall, oIllegal;
  int         n_cmp = 0;
  int         n_err = 0;

  control_pipe #(.REG_ADDR_W(5), .LOAD_STALL_CYC(2), .MULDIV_LAT(4)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iValid(iValid), .iOp(iOp), .iFunct(iFunct),
    .iRs(iRs), .iRt(iRt), .iRd(iRd), .iFlush(iFlush),
    .oValid(oValid), .oRegDst(oRegDst), .oOrigALU(oOrigALU), .oMemparaReg(oMemparaReg),
    .oEscreveReg(oEscreveReg), .oLeMem(oLeMem), .oEscreveMem(oEscreveMem), .oJump(oJump),
    .oBranch(oBranch), .onBranch(onBranch), .oJr(oJr), .oOpALU(oOpALU), .oOrigPC(oOrigPC),
    .oDestReg(oDestReg), .oStall(oStall), .oIllegal(oIllegal)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setin(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl);
    iValid = v; iOp = op; iFunct = fn; iRs = rs; iRt = rt; iRd = rd; iFlush = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRST_n = 1'b0;
    setin(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0);
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_pc", 32'(oOrigPC), 32'd0);
    chk("rst_ill", 32'(oIllegal), 32'd0);
    chk("rst_stall", 32'(oStall), 32'd0);
    iRST_n = 1'b1;

    // LW $8 then ADD rs=$8: two bubbles, then ADD
    setin(1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 0);
    chk("lw_nostall", 32'(oStall), 32'd0);
    tick;
    chk("lw_valid", 32'(oValid), 32'd1);
    chk("lw_rdm", 32'(oLeMem), 32'd1);
    chk("lw_dest", 32'(oDestReg), 32'd8);
    chk("lw_alu", 32'(oOrigALU), 32'd1);
    setin(1, 6'h00, 6'h20, 5'd8, 5'd2, 5'd9, 0);
    chk("lu_stall0", 32'(oStall), 32'd1);
    tick;
    chk("lu_bub1", 32'(oValid), 32'd0);
    chk("lu_bub1_dest", 32'(oDestReg), 32'd0);
    chk("lu_stall1", 32'(oStall), 32'd1);
    tick;
    chk("lu_bub2", 32'(oValid), 32'd0);
    chk("lu_stall2", 32'(oStall), 32'd0);
    tick;
    chk("add_valid", 32'(oValid), 32'd1);
    chk("add_regdst", 32'(oRegDst), 32'd1);
    chk("add_dest", 32'(oDestReg), 32'd9);
    chk("add_opalu", 32'(oOpALU), 32'd2);
    chk("add_mem", 32'(oMemparaReg), 32'd1);

    // LW $0 never stalls
    setin(1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 0);
    tick;
    setin(1, 6'h00, 6'h20, 5'd0, 5'd2, 5'd9, 0);
    chk("lw0_nostall", 32'(oStall), 32'd0);
    tick;
    chk("lw0_add_valid", 32'(oValid), 32'd1);

    // ADDI does not read rt
    setin(1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 0);
    tick;
    setin(1, 6'h08, 6'h00, 5'd3, 5'd8, 5'd0, 0);
    chk("addi_nostall", 32'(oStall), 32'd0);
    tick;
    chk("addi_alu", 32'(oOrigALU), 32'd1);
    chk("addi_opalu", 32'(oOpALU), 32'd3);
    chk("addi_dest", 32'(oDestReg), 32'd8);

    // BEQ reads rt
    setin(1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 0);
    tick;
    setin(1, 6'h04, 6'h00, 5'd3, 5'd8, 5'd0, 0);
    chk("beq_stall", 32'(oStall), 32'd1);
    tick;
    tick;
    chk("beq_stall_end", 32'(oStall), 32'd0);
    tick;
    chk("beq_pc", 32'(oOrigPC), 32'd1);
    chk("beq_br", 32'(oBranch), 32'd1);
    chk("beq_opalu", 32'(oOpALU), 32'd1);

    // JAL flushed while a load-use hazard is present
    setin(1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 0);
    tick;
    setin(1, 6'h03, 6'h00, 5'd8, 5'd0, 5'd0, 1);
    chk("fl_stall", 32'(oStall), 32'd0);
    tick;
    chk("fl_bubble", 32'(oValid), 32'd0);
    setin(1, 6'h03, 6'h00, 5'd8, 5'd0, 5'd0, 0);
    chk("fl_cnt_clr", 32'(oStall), 32'd0);
    tick;
    chk("jal_regdst", 32'(oRegDst), 32'd2);
    chk("jal_dest", 32'(oDestReg), 32'd31);
    chk("jal_pc", 32'(oOrigPC), 32'd2);
    chk("jal_jump", 32'(oJump), 32'd1);
    chk("jal_mem", 32'(oMemparaReg), 32'd2);

    // SW, LUI, empty slot
    setin(1, 6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 0);
    tick;
    chk("sw_wrm", 32'(oEscreveMem), 32'd1);
    chk("sw_wr", 32'(oEscreveReg), 32'd0);
    setin(1, 6'h0F, 6'h00, 5'd0, 5'd6, 5'd0, 0);
    tick;
    chk("lui_alu", 32'(oOrigALU), 32'd3);
    chk("lui_mem", 32'(oMemparaReg), 32'd3);
    chk("lui_dest", 32'(oDestReg), 32'd6);
    setin(0, 6'h0F, 6'h00, 5'd0, 5'd6, 5'd0, 0);
    tick;
    chk("inv_valid", 32'(oValid), 32'd0);
    chk("inv_pc", 32'(oOrigPC), 32'd0);

`ifdef CTRL_MULDIV_EN
    setin(1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 0);
    tick;
    chk("mult_wr", 32'(oEscreveReg), 32'd0);
    chk("mult_opalu", 32'(oOpALU), 32'd2);
    setin(1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd4, 0);
    chk("mflo_stall0", 32'(oStall), 32'd1);
    tick;
    chk("mflo_bub", 32'(oValid), 32'd0);
    chk("mflo_stall1", 32'(oStall), 32'd1);
    tick;
    chk("mflo_stall2", 32'(oStall), 32'd1);
    tick;
    chk("mflo_stall3", 32'(oStall), 32'd0);
    tick;
    chk("mflo_valid", 32'(oValid), 32'd1);
    chk("mflo_dest", 32'(oDestReg), 32'd4);
    setin(1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 0);
    tick;
    setin(1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd9, 0);
    chk("md_add_nostall", 32'(oStall), 32'd0);
    tick;
    chk("md_add_valid", 32'(oValid), 32'd1);
`endif

    // Illegal opcode: flush blocks capture, then sticky
    setin(1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1);
    tick;
    chk("ill_flushed", 32'(oIllegal), 32'd0);
    setin(1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 0);
    tick;
    chk("ill_valid", 32'(oValid), 32'd1);
    chk("ill_pc", 32'(oOrigPC), 32'd7);
    chk("ill_set", 32'(oIllegal), 32'd1);
    setin(1, 6'h0D, 6'h00, 5'd0, 5'd5, 5'd0, 0);
    tick;
    chk("ill_sticky", 32'(oIllegal), 32'd1);
    chk("ori_alu", 32'(oOrigALU), 32'd2);
    chk("ori_dest", 32'(oDestReg), 32'd5);

    // Asynchronous reset mid-stream
    iRST_n = 1'b0;
    #1;
    chk("arst_valid", 32'(oValid), 32'd0);
    chk("arst_ill", 32'(oIllegal), 32'd0);
    chk("arst_dest", 32'(oDestReg), 32'd0);
    chk("arst_opalu", 32'(oOpALU), 32'd0);
    chk("arst_stall", 32'(oStall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
